// File: rtl/period_display.sv
`default_nettype none
// ============================================================================
// Module   : period_display
// Purpose  : Takes each new 10-bit period count from the period meter and
//            converts it to four BCD digits with a sequential double-dabble
//            engine (one add-3/shift step per clock). The last result is held
//            and shown on a time-multiplexed 4-digit common-anode
//            seven-segment display, with optional leading-zero blanking.
//
// Ports    : clk     in   system clock, all state on the rising edge
//            rst_n   in   asynchronous active-low reset
//            p_in    in   [9:0]  binary period value, 0..1023
//            p_load  in   strobe, p_in valid this cycle
//            busy    out  conversion in progress (SHIFT or DONE)
//            bcd     out  [15:0] last converted value, [15:12] = thousands
//            an      out  [3:0]  digit enables, active-low, one-hot-low
//            seg     out  [6:0]  segments {g,f,e,d,c,b,a}, active-low
//
// Revision : 1.0  initial release
// ============================================================================
module period_display #(
  parameter int SCAN_DIV = 50000,  // clocks per digit slot, >= 2
  parameter bit BLANK_LZ = 1'b1    // 1 = blank leading zero digits
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  p_in,
  input  logic        p_load,
  output logic        busy,
  output logic [15:0] bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int              SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // 10 input bits need exactly 10 shifts; the count runs 0..9.
  localparam logic [3:0] LAST_ITER = 4'd9;

  // --------------------------------------------------------------------------
  // Conversion state
  // --------------------------------------------------------------------------
  logic [1:0]  state;
  logic [25:0] sr;        // {thousands, hundreds, tens, units, binary[9:0]}
  logic [3:0]  iter;
  logic        pend;
  logic [9:0]  pend_val;

  // Add-3 correction on each BCD nibble of the shift register, applied
  // before the shift in the same clock.
  logic [15:0] bcd_adj;

  for (genvar d = 0; d < 4; d++) begin : g_adj
    logic [3:0] nib;
    assign nib = sr[10 + 4*d +: 4];
    assign bcd_adj[4*d +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sr       <= 26'd0;
      iter     <= 4'd0;
      pend     <= 1'b0;
      pend_val <= 10'd0;
      bcd      <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          // A fresh strobe beats the parked value; either way the parked
          // slot is consumed (or discarded) here.
          if (p_load) begin
            sr    <= {16'h0000, p_in};
            iter  <= 4'd0;
            pend  <= 1'b0;
            state <= S_SHIFT;
          end else if (pend) begin
            sr    <= {16'h0000, pend_val};
            iter  <= 4'd0;
            pend  <= 1'b0;
            state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (p_load) begin
            pend     <= 1'b1;
            pend_val <= p_in;
          end
          sr   <= {bcd_adj, sr[9:0]} << 1;
          iter <= iter + 4'd1;
          if (iter == LAST_ITER) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          // A strobe landing on this cycle is parked and picked up by the
          // following IDLE cycle.
          if (p_load) begin
            pend     <= 1'b1;
            pend_val <= p_in;
          end
          bcd   <= sr[25:10];
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Display scan
  // --------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // blank_digit[i] is set when nibble i and every nibble above it is zero.
  // Digit 0 always shows, so a value of zero still reads "0".
  logic [3:0] blank_digit;

  assign blank_digit[3] = (bcd[15:12] == 4'd0);
  assign blank_digit[2] = blank_digit[3] && (bcd[11:8] == 4'd0);
  assign blank_digit[1] = blank_digit[2] && (bcd[7:4]  == 4'd0);
  assign blank_digit[0] = 1'b0;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [3:0] nib_sel;
  logic       blank_now;
  logic [6:0] seg_next;
  logic [3:0] an_next;

  always_comb begin
    nib_sel   = bcd[{digit, 2'b00} +: 4];
    blank_now = BLANK_LZ && blank_digit[digit];
    seg_next  = blank_now ? 7'b1111111 : seg_decode(nib_sel);
    an_next   = ~(4'b0001 << digit);
  end

  // Outputs are refreshed every clock from the current digit and bcd, so a
  // new result appears without waiting for a scan boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_period_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_period_display
// Purpose  : Directed self-checking bench for period_display. Two instances
//            share all inputs: one with leading-zero blanking, one without,
//            both with a 4-clock scan slot.
// Revision : 1.0  initial release
// ============================================================================
module tb_period_display;

  logic        clk;
  logic        rst_n;
  logic [9:0]  p_in;
  logic        p_load;

  logic        busy_b, busy_f;
  logic [15:0] bcd_b, bcd_f;
  logic [3:0]  an_b, an_f;
  logic [6:0]  seg_b, seg_f;

  int n_checks = 0;
  int n_pass   = 0;

  period_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_blank (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_load(p_load),
    .busy(busy_b), .bcd(bcd_b), .an(an_b), .seg(seg_b)
  );

  period_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_load(p_load),
    .busy(busy_f), .bcd(bcd_f), .an(an_f), .seg(seg_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one value; returns positioned just after the sampling edge (E0).
  task automatic pulse_load(input logic [9:0] v);
    p_in   = v;
    p_load = 1'b1;
    tick();
    p_load = 1'b0;
  endtask

  // Counts sampled cycles with busy high, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy_b && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  function automatic int idx_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i, input bit blz);
    logic [3:0] n;
    if (i < 0) return 7'bxxxxxxx;
    n = v[4*i +: 4];
    if (blz && i > 0 && (v >> (4*i)) == 16'd0) return 7'b1111111;
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Locks onto an anode change, then checks four full slots of 4 clocks.
  task automatic scan_check(input logic [15:0] v);
    logic [3:0] prev, exp_an;
    int n;
    prev = an_b;
    n = 0;
    while (an_b == prev && n < 10) begin
      tick();
      n++;
    end
    chk("scan_sync", 32'(an_b != prev), 32'd1);
    chk("an_onehot", 32'(idx_of(an_b) >= 0), 32'd1);
    exp_an = an_b;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        chk("an_blank", 32'(an_b), 32'(exp_an));
        chk("an_full", 32'(an_f), 32'(exp_an));
        chk("seg_blank", 32'(seg_b), 32'(exp_seg(v, idx_of(exp_an), 1'b1)));
        chk("seg_full", 32'(seg_f), 32'(exp_seg(v, idx_of(exp_an), 1'b0)));
        tick();
      end
      exp_an = {exp_an[2:0], exp_an[3]};
    end
  endtask

  logic [9:0]  vec_in  [5] = '{10'd1023, 10'd0, 10'd9, 10'd512, 10'd7};
  logic [15:0] vec_bcd [5] = '{16'h1023, 16'h0000, 16'h0009, 16'h0512, 16'h0007};

  initial begin
    int cnt;
    rst_n  = 1'b1;
    p_in   = 10'd0;
    p_load = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_b), 32'd0);
    chk("rst_bcd", 32'(bcd_b), 32'h0);
    chk("rst_an", 32'(an_b), 32'b1110);
    chk("rst_seg", 32'(seg_b), 32'b1000000);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("idle_busy", 32'(busy_b), 32'd0);
    chk("idle_bcd", 32'(bcd_b), 32'h0);
    scan_check(16'h0000);

    // Single conversions: 11-cycle busy, result on the 11th edge.
    for (int k = 0; k < 5; k++) begin
      pulse_load(vec_in[k]);
      wait_idle(cnt);
      chk("conv_latency", 32'(cnt), 32'd11);
      chk("conv_bcd", 32'(bcd_b), 32'(vec_bcd[k]));
      chk("conv_bcd_full", 32'(bcd_f), 32'(vec_bcd[k]));
    end
    scan_check(16'h0007);

    // Loads while busy: latest pending value wins, 42 is dropped.
    pulse_load(10'd500);
    tick(); tick();
    pulse_load(10'd42);
    tick(); tick();
    pulse_load(10'd99);
    wait_idle(cnt);
    chk("pend_first_lat", 32'(cnt), 32'd5);
    chk("pend_first_bcd", 32'(bcd_b), 32'h0500);
    tick();
    chk("pend_restart", 32'(busy_b), 32'd1);
    wait_idle(cnt);
    chk("pend_second_lat", 32'(cnt), 32'd11);
    chk("pend_second_bcd", 32'(bcd_b), 32'h0099);
    repeat (15) tick();
    chk("pend_no_third", 32'(busy_b), 32'd0);

    // Load landing on the DONE cycle.
    pulse_load(10'd1000);
    repeat (10) tick();
    pulse_load(10'd305);
    chk("done_busy", 32'(busy_b), 32'd0);
    chk("done_bcd", 32'(bcd_b), 32'h1000);
    tick();
    chk("done_restart", 32'(busy_b), 32'd1);
    wait_idle(cnt);
    chk("done_second_lat", 32'(cnt), 32'd11);
    chk("done_second_bcd", 32'(bcd_b), 32'h0305);
    scan_check(16'h0305);

    // Reset mid-conversion with a value parked in pending.
    pulse_load(10'd888);
    tick(); tick();
    pulse_load(10'd11);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_b), 32'd0);
    chk("midrst_bcd", 32'(bcd_b), 32'h0);
    chk("midrst_an", 32'(an_b), 32'b1110);
    chk("midrst_seg", 32'(seg_b), 32'b1000000);
    tick();
    rst_n = 1'b1;
    repeat (15) tick();
    chk("midrst_no_pend", 32'(busy_b), 32'd0);
    chk("midrst_bcd_hold", 32'(bcd_b), 32'h0);
    pulse_load(10'd64);
    wait_idle(cnt);
    chk("post_rst_lat", 32'(cnt), 32'd11);
    chk("post_rst_bcd", 32'(bcd_b), 32'h0064);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
